// File: rtl/pipe_addsub.sv
`timescale 1ns/1ps
// pipe_addsub: adder/subtractor pipelined SEG bits per stage, carry handed stage to stage, valid/ready flow control.
// Define PIPE_ADDSUB_SAT_EN to clamp Out on overflow; without it Out is the wrapped result.
module pipe_addsub #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] InA,
    input  logic [WIDTH-1:0] InB,
    input  logic             Cin,
    input  logic             sub,
    input  logic             sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             Ofl,
    output logic             c_out,
    output logic             zero
);
    // WIDTH must be a multiple of SEG giving at least two stages.
    localparam int STAGES = WIDTH / SEG;

    // Stages 0..STAGES-2 keep operands, partial sum and carry; the last stage writes the output flops.
    logic [WIDTH-1:0]  a_q   [STAGES-1];
    logic [WIDTH-1:0]  b_q   [STAGES-1];
    logic [WIDTH-1:0]  sum_q [STAGES-1];
    logic [STAGES-2:0] carry_q;
    logic [STAGES-2:0] sub_q;
    logic [STAGES-2:0] sign_q;

    logic [STAGES-1:0] valid;
    logic [STAGES-1:0] ready;
    logic [STAGES-1:0] valid_in;

    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic [STAGES-1:0] carry_d;
    logic [STAGES-1:0] sub_d;
    logic [STAGES-1:0] sign_d;

    logic [WIDTH-1:0]  out_q;
    logic              ofl_q;
    logic              c_out_q;
    logic              zero_q;

    logic [WIDTH-1:0]  raw_d;
    logic [WIDTH-1:0]  res_d;
    logic              ofl_d;
    logic              zero_d;
    logic              a_msb;
    logic              b_msb;

    assign valid_in  = {valid[STAGES-2:0], in_valid};
    assign in_ready  = ready[0];
    assign out_valid = valid[STAGES-1];
    assign Out       = out_q;
    assign Ofl       = ofl_q;
    assign c_out     = c_out_q;
    assign zero      = zero_q;

    // A stage can take new data when it is empty or its occupant moves on this same cycle.
    always_comb begin
        logic r;
        ready = '0;
        r = !valid[STAGES-1] || out_ready;
        ready[STAGES-1] = r;
        for (int k = STAGES - 2; k >= 0; k--) begin
            r = !valid[k] || r;
            ready[k] = r;
        end
    end

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            logic [WIDTH-1:0] prev_sum;
            logic             c_seg;
            logic [SEG:0]     seg;

            if (k == 0) begin : g_head
                // Subtraction is A + ~B + 1, so the incoming carry is forced high.
                assign a_d[k]    = InA;
                assign b_d[k]    = sub ? ~InB : InB;
                assign c_seg     = sub | Cin;
                assign prev_sum  = '0;
                assign sub_d[k]  = sub;
                assign sign_d[k] = sign;
            end else begin : g_body
                assign a_d[k]    = a_q[k-1];
                assign b_d[k]    = b_q[k-1];
                assign c_seg     = carry_q[k-1];
                assign prev_sum  = sum_q[k-1];
                assign sub_d[k]  = sub_q[k-1];
                assign sign_d[k] = sign_q[k-1];
            end

            assign seg        = {1'b0, a_d[k][k*SEG +: SEG]} + {1'b0, b_d[k][k*SEG +: SEG]}
                              + {{SEG{1'b0}}, c_seg};
            assign carry_d[k] = seg[SEG];
            assign sum_d[k]   = prev_sum | ({{(WIDTH-SEG){1'b0}}, seg[SEG-1:0]} << (k*SEG));
        end
    endgenerate

    // Overflow uses the effective (possibly inverted) second operand's sign bit.
    always_comb begin
        raw_d = sum_d[STAGES-1];
        a_msb = a_d[STAGES-1][WIDTH-1];
        b_msb = b_d[STAGES-1][WIDTH-1];
        if (sign_d[STAGES-1]) begin
            ofl_d = (a_msb == b_msb) && (raw_d[WIDTH-1] != a_msb);
        end else begin
            ofl_d = sub_d[STAGES-1] ? ~carry_d[STAGES-1] : carry_d[STAGES-1];
        end
        res_d = raw_d;
`ifdef PIPE_ADDSUB_SAT_EN
        if (ofl_d) begin
            if (sign_d[STAGES-1]) begin
                res_d = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            end else begin
                res_d = sub_d[STAGES-1] ? '0 : '1;
            end
        end
`endif
        zero_d = (res_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid   <= '0;
            carry_q <= '0;
            sub_q   <= '0;
            sign_q  <= '0;
            for (int i = 0; i < STAGES - 1; i++) begin
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                sum_q[i] <= '0;
            end
            out_q   <= '0;
            ofl_q   <= 1'b0;
            c_out_q <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            for (int i = 0; i < STAGES - 1; i++) begin
                if (ready[i]) begin
                    valid[i] <= valid_in[i];
                    if (valid_in[i]) begin
                        a_q[i]     <= a_d[i];
                        b_q[i]     <= b_d[i];
                        sum_q[i]   <= sum_d[i];
                        carry_q[i] <= carry_d[i];
                        sub_q[i]   <= sub_d[i];
                        sign_q[i]  <= sign_d[i];
                    end
                end
            end
            if (ready[STAGES-1]) begin
                valid[STAGES-1] <= valid_in[STAGES-1];
                if (valid_in[STAGES-1]) begin
                    out_q   <= res_d;
                    ofl_q   <= ofl_d;
                    c_out_q <= carry_d[STAGES-1];
                    zero_q  <= zero_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_addsub.sv
`timescale 1ns/1ps
// tb_pipe_addsub: directed vectors for pipe_addsub (WIDTH=16, SEG=4), plus backpressure and mid-flight reset sequences.
// Expected Out follows PIPE_ADDSUB_SAT_EN when it is defined.
module tb_pipe_addsub;
    localparam int WIDTH = 16;
    localparam int SEG   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] InA;
    logic [WIDTH-1:0] InB;
    logic             Cin;
    logic             sub;
    logic             sign;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Out;
    logic             Ofl;
    logic             c_out;
    logic             zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic        sign;
        logic [15:0] out_wrap;
        logic [15:0] out_sat;
        logic        ofl;
        logic        cout;
    } vec_t;

    vec_t vecs [12];
    vec_t bp   [6];

    pipe_addsub #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .InA      (InA),
        .InB      (InB),
        .Cin      (Cin),
        .sub      (sub),
        .sign     (sign),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Out      (Out),
        .Ofl      (Ofl),
        .c_out    (c_out),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [15:0] exp_out(input vec_t v);
`ifdef PIPE_ADDSUB_SAT_EN
        return v.out_sat;
`else
        return v.out_wrap;
`endif
    endfunction

    task automatic apply_stimulus(input vec_t v);
        InA  = v.a;
        InB  = v.b;
        Cin  = v.cin;
        sub  = v.sub;
        sign = v.sign;
    endtask

    task automatic check_output(input string what, input int idx, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s[%0d]: got 0x%0h expected 0x%0h", what, idx, act, expv);
        end
    endtask

    // Waits for out_valid after a transfer edge; returns the number of rising edges including the transfer edge.
    task automatic wait_result(output int edges);
        edges = 1;
        @(negedge clk);
        while (!out_valid && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    initial begin
        int edges;
        int sent;
        int got;
        int cyc;
        int seen;
        logic acc;

        vecs[0]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h8000, 16'h7FFF, 1'b1, 1'b0};
        vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 1'b1, 1'b1};
        vecs[2]  = '{16'h0003, 16'h0005, 1'b0, 1'b1, 1'b0, 16'hFFFE, 16'h0000, 1'b1, 1'b0};
        vecs[3]  = '{16'h0003, 16'h0005, 1'b0, 1'b1, 1'b1, 16'hFFFE, 16'hFFFE, 1'b0, 1'b0};
        vecs[4]  = '{16'h1234, 16'h0FFF, 1'b1, 1'b0, 1'b0, 16'h2234, 16'h2234, 1'b0, 1'b0};
        vecs[5]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h8000, 1'b1, 1'b1};
        vecs[6]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h7FFF, 16'h8000, 1'b1, 1'b1};
        vecs[7]  = '{16'h0005, 16'h0005, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1};
        vecs[8]  = '{16'h0010, 16'h0001, 1'b1, 1'b1, 1'b0, 16'h000F, 16'h000F, 1'b0, 1'b1};
        vecs[9]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, 16'h5555, 16'h5555, 1'b0, 1'b0};
        vecs[10] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1};
        vecs[11] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};

        for (int i = 0; i < 6; i++) begin
            bp[i].a        = 16'(16'h0101 * (i + 1));
            bp[i].b        = 16'h0011;
            bp[i].cin      = 1'b0;
            bp[i].sub      = 1'b0;
            bp[i].sign     = 1'b0;
            bp[i].out_wrap = 16'(bp[i].a + bp[i].b);
            bp[i].out_sat  = bp[i].out_wrap;
            bp[i].ofl      = 1'b0;
            bp[i].cout     = 1'b0;
        end

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        apply_stimulus(vecs[11]);

        #12;
        check_output("rst_out_valid", 0, 32'(out_valid), 32'd0);
        check_output("rst_Out",       0, 32'(Out),       32'd0);
        check_output("rst_Ofl",       0, 32'(Ofl),       32'd0);
        check_output("rst_c_out",     0, 32'(c_out),     32'd0);
        check_output("rst_zero",      0, 32'(zero),      32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("in_ready_after_rst", 0, 32'(in_ready), 32'd1);

        // Single transactions: latency and arithmetic per vector.
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            apply_stimulus(vecs[i]);
            in_valid = 1'b1;
            #1;
            check_output("in_ready", i, 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            wait_result(edges);
            check_output("out_valid", i, 32'(out_valid), 32'd1);
            check_output("latency",   i, 32'(edges), 32'd4);
            check_output("Out",       i, 32'(Out),   32'(exp_out(vecs[i])));
            check_output("Ofl",       i, 32'(Ofl),   32'(vecs[i].ofl));
            check_output("c_out",     i, 32'(c_out), 32'(vecs[i].cout));
            check_output("zero",      i, 32'(zero),  32'(exp_out(vecs[i]) == 16'h0000));
            @(posedge clk);
        end

        // Backpressure: fill with out_ready low, hold, then drain in order.
        @(negedge clk);
        out_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            apply_stimulus(bp[sent]);
            in_valid = 1'b1;
            #1;
            if (!in_ready) break;
            @(posedge clk);
            sent++;
        end
        check_output("bp_accepted", 0, 32'(sent), 32'd4);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check_output("bp_stall_in_ready",  c, 32'(in_ready),  32'd0);
            check_output("bp_stall_out_valid", c, 32'(out_valid), 32'd1);
            check_output("bp_stall_Out",       c, 32'(Out),       32'(bp[0].out_wrap));
        end
        out_ready = 1'b1;
        got = 0;
        cyc = 0;
        while (got < 6 && cyc < 30) begin
            if (sent < 6) begin
                apply_stimulus(bp[sent]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            acc = in_ready && in_valid;
            if (out_valid) begin
                check_output("bp_order_Out", got, 32'(Out), 32'(bp[got].out_wrap));
                got++;
            end
            @(posedge clk);
            if (acc) sent++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check_output("bp_results", 0, 32'(got), 32'd6);
        check_output("bp_cycles",  0, 32'(cyc), 32'd6);

        // Reset with three transactions in flight.
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            apply_stimulus(vecs[9]);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check_output("midrst_out_valid", 0, 32'(out_valid), 32'd0);
        check_output("midrst_Out",       0, 32'(Out),       32'd0);
        check_output("midrst_zero",      0, 32'(zero),      32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("midrst_in_ready", 0, 32'(in_ready), 32'd1);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check_output("midrst_ghosts", 0, 32'(seen), 32'd0);

        @(negedge clk);
        apply_stimulus(vecs[4]);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_result(edges);
        check_output("post_rst_out_valid", 0, 32'(out_valid), 32'd1);
        check_output("post_rst_latency",   0, 32'(edges),     32'd4);
        check_output("post_rst_Out",       0, 32'(Out),       32'h2234);
        @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_addsub.md
PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, meaning the operand and result width in bits.
REQ-002 The module SHALL have parameter SEG, default 4, meaning the bits added per pipeline stage; WIDTH SHALL be a multiple of SEG, and STAGES = WIDTH/SEG.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port in_valid, input, 1 bit: the operand set is presented.
REQ-006 The module SHALL have port in_ready, output, 1 bit: stage 0 can accept this cycle.
REQ-007 The module SHALL have ports InA and InB, input, WIDTH bits each: the operands.
REQ-008 The module SHALL have port Cin, input, 1 bit: the carry-in, used only when sub=0.
REQ-009 The module SHALL have port sub, input, 1 bit: 1 selects subtraction.
REQ-010 The module SHALL have port sign, input, 1 bit: 1 selects signed overflow, 0 selects unsigned.
REQ-011 The module SHALL have port out_valid, output, 1 bit: a result is held at the output.
REQ-012 The module SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 The module SHALL have port Out, output, WIDTH bits: the result.
REQ-014 The module SHALL have port Ofl, output, 1 bit: the overflow flag.
REQ-015 The module SHALL have port c_out, output, 1 bit: the raw carry out of the MSB.
REQ-016 The module SHALL have port zero, output, 1 bit: asserted when Out equals 0.

Function
REQ-017 A transfer SHALL occur on a rising clk edge when both in_valid and in_ready are 1; the output transfer occurs when both out_valid and out_ready are 1.
REQ-018 Arithmetic SHALL be: for sub=0, Out = InA + InB + Cin; for sub=1, Out = InA + ~InB + 1, with Cin ignored; the result is taken modulo 2^WIDTH.
REQ-019 Stage k (k = 0..STAGES-1) SHALL add bits [k*SEG+SEG-1 : k*SEG] using the carry registered by stage k-1, and forward the unprocessed upper operand bits together with sub and sign.
REQ-020 Latency SHALL be exactly STAGES cycles from the input transfer to out_valid=1 when there are no stalls (4 cycles at the default parameters).
REQ-021 Throughput SHALL be one transfer per cycle while out_ready=1.
REQ-022 Each stage SHALL hold one valid bit, and SHALL advance when the next stage is empty or advancing in the same cycle; in_ready SHALL equal !valid0 OR stage0-advances, combinationally, with no bubble on a simultaneous enter and leave.
REQ-023 A full pipeline with out_ready=0 SHALL hold every stage's contents unchanged and drive in_ready=0.
REQ-024 Results SHALL leave in input order, with none lost or duplicated.
REQ-025 Out, Ofl, c_out and zero SHALL be registered and SHALL stay stable while out_valid=1 and out_ready=0.
REQ-026 c_out SHALL be the carry out of bit WIDTH-1.
REQ-027 When sign=1, Ofl SHALL equal (A[MSB] == B'[MSB]) AND (Out[MSB] != A[MSB]), where B' is the effective, possibly inverted, second operand.
REQ-028 When sign=0, Ofl SHALL equal c_out for sub=0, and ~c_out (the borrow) for sub=1.

Reset
REQ-029 While rst=1, all stage valid bits, out_valid, Out, Ofl and c_out SHALL be 0 and zero SHALL be 1, asynchronously.
REQ-030 On the first clock after reset is released, in_ready SHALL be 1.
REQ-031 Reset asserted mid-operation SHALL discard every in-flight transaction, and no result for those transactions SHALL ever appear.

Configuration
REQ-032 The macro PIPE_ADDSUB_SAT_EN SHALL control saturation.
REQ-033 With PIPE_ADDSUB_SAT_EN defined, when Ofl=1 the module SHALL saturate Out: signed results clamp to 0111..1 on positive overflow and to 1000..0 on negative overflow; unsigned addition clamps to all-ones; unsigned subtraction clamps to 0. Ofl and c_out SHALL keep their unsaturated values, and zero SHALL follow the saturated Out.
REQ-034 Without PIPE_ADDSUB_SAT_EN, Out SHALL be the wrapped result, and no saturation logic SHALL be present.

Verification (WIDTH=16, SEG=4)
REQ-035 The bench SHALL cover: InA=0x7FFF, InB=0x0001, sub=0, sign=1, Cin=0 -> Out=0x8000, Ofl=1, c_out=0 (0x7FFF with SAT_EN); out_valid rises exactly 4 cycles after the input transfer.
REQ-036 The bench SHALL cover: InA=0xFFFF, InB=0x0001, sub=0, sign=0 -> Out=0x0000, Ofl=1, c_out=1, zero=1 (0xFFFF and zero=0 with SAT_EN).
REQ-037 The bench SHALL cover: InA=0x0003, InB=0x0005, sub=1, sign=0 -> Out=0xFFFE, c_out=0, Ofl=1 (0x0000 with SAT_EN); with sign=1, the same operands give Ofl=0.
REQ-038 The bench SHALL cover: 6 back-to-back inputs with out_ready=0 -> in_ready falls after 4 are accepted and outputs stay stable; then out_ready=1 -> all 6 results appear in order, one per cycle.
REQ-039 The bench SHALL cover: rst pulsed with 3 transactions in flight -> out_valid=0 immediately, those 3 results never appear, and a new transfer completes in 4 cycles.
REQ-040 The bench SHALL cover: InA=0x1234, InB=0x0FFF, Cin=1, sub=0 -> Out=0x2234, with the carry rippling across all 4 stages.
